// File: rtl/bitrev_arb_if.sv
// Requester, response and core-side handshake bundle for bitrev_arb.
// slave = arbiter view; master = the surrounding fabric (sources, sinks and core).
interface bitrev_arb_if #(
   parameter int NREQ = 4,
   parameter int DW   = 32
);
   logic [NREQ-1:0]    req_valid_i;
   logic [NREQ*DW-1:0] req_data_i;
   logic [NREQ-1:0]    req_ready_o;
   logic [NREQ-1:0]    rsp_valid_o;
   logic [NREQ*DW-1:0] rsp_data_o;
   logic [NREQ-1:0]    rsp_ready_i;
   logic               core_valid_o;
   logic [DW-1:0]      core_data_o;
   logic               core_ready_i;
   logic               core_valid_i;
   logic [DW-1:0]      core_data_i;
   logic               core_ready_o;

   modport slave (
      input  req_valid_i, req_data_i, rsp_ready_i, core_ready_i, core_valid_i, core_data_i,
      output req_ready_o, rsp_valid_o, rsp_data_o, core_valid_o, core_data_o, core_ready_o
   );

   modport master (
      output req_valid_i, req_data_i, rsp_ready_i, core_ready_i, core_valid_i, core_data_i,
      input  req_ready_o, rsp_valid_o, rsp_data_o, core_valid_o, core_data_o, core_ready_o
   );
endinterface

// File: rtl/bitrev_arb.sv
// Frame-granular arbiter sharing one bitrev core among NREQ streams; an owner FIFO steers
// each reordered frame back to its requester. Define BITREV_ARB_PRIO_EN for fixed priority on requester 0.
module bitrev_arb #(
   parameter int NREQ      = 4,
   parameter int K         = 10,
   parameter int DW        = 32,
   parameter int OWN_DEPTH = 2
) (
   input  logic        clk_i,
   input  logic        rst_ni,
   bitrev_arb_if.slave bus,
   output logic        busy_o,
   output logic        frame_done_o
);
   localparam int GW = (NREQ > 1) ? $clog2(NREQ) : 1;
   localparam int PW = (OWN_DEPTH > 1) ? $clog2(OWN_DEPTH) : 1;
   localparam int CW = $clog2(OWN_DEPTH + 1);
   localparam logic [K-1:0] CNT_LAST = {K{1'b1}};

`ifdef BITREV_ARB_PRIO_EN
   localparam bit PRIO_EN = 1'b1;
`else
   localparam bit PRIO_EN = 1'b0;
`endif

   typedef enum logic {IDLE, LOCK} state_t;

   state_t        state_reg, state_next;
   logic [GW-1:0] grant_reg, grant_next;
   logic [GW-1:0] last_grant_reg, last_grant_next;
   logic [K-1:0]  in_cnt_reg, in_cnt_next;
   logic [K-1:0]  out_cnt_reg;
   logic [GW-1:0] own_mem [OWN_DEPTH];
   logic [PW-1:0] wr_ptr_reg, rd_ptr_reg;
   logic [CW-1:0] count_reg;
   logic [DW-1:0] req_data_arr [NREQ];

   logic [GW-1:0] winner;
   logic [GW-1:0] head;
   logic          any_req;
   logic          push, pop;
   logic          in_hs, out_hs;
   logic          fifo_empty, fifo_full;

   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == PW'(OWN_DEPTH - 1)) ? '0 : p + PW'(1);
   endfunction

   // Non-owner response lanes simply mirror the core data; only rsp_valid_o is qualified.
   for (genvar gi = 0; gi < NREQ; gi++) begin : g_lane
      assign req_data_arr[gi]               = bus.req_data_i[gi*DW +: DW];
      assign bus.rsp_data_o[gi*DW +: DW]    = bus.core_data_i;
   end

   assign head       = own_mem[rd_ptr_reg];
   assign fifo_empty = (count_reg == '0);
   assign fifo_full  = (count_reg == CW'(OWN_DEPTH));

   // Round-robin search from last_grant+1; with priority enabled requester 0 preempts the search.
   always_comb begin
      int            idx;
      logic [GW-1:0] cand;
      winner  = '0;
      any_req = 1'b0;
      idx     = 0;
      cand    = '0;
      if (PRIO_EN && bus.req_valid_i[0]) begin
         winner  = '0;
         any_req = 1'b1;
      end
      for (int i = 1; i <= NREQ; i++) begin
         idx = int'(last_grant_reg) + i;
         if (idx >= NREQ) idx = idx - NREQ;
         cand = GW'(idx);
         if (!any_req && bus.req_valid_i[cand] && !(PRIO_EN && cand == '0)) begin
            winner  = cand;
            any_req = 1'b1;
         end
      end
   end

   assign in_hs = (state_reg == LOCK) && bus.req_valid_i[grant_reg] && bus.core_ready_i;

   always_comb begin
      state_next      = state_reg;
      grant_next      = grant_reg;
      last_grant_next = last_grant_reg;
      in_cnt_next     = in_cnt_reg;
      push            = 1'b0;
      case (state_reg)
         IDLE: begin
            if (any_req && !fifo_full) begin
               grant_next      = winner;
               last_grant_next = winner;
               in_cnt_next     = '0;
               push            = 1'b1;
               state_next      = LOCK;
            end
         end
         LOCK: begin
            if (in_hs) begin
               in_cnt_next = in_cnt_reg + K'(1);
               if (in_cnt_reg == CNT_LAST) state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   always_comb begin
      bus.req_ready_o  = '0;
      bus.core_valid_o = 1'b0;
      bus.core_data_o  = '0;
      if (state_reg == LOCK) begin
         bus.core_valid_o           = bus.req_valid_i[grant_reg];
         bus.core_data_o            = req_data_arr[grant_reg];
         bus.req_ready_o[grant_reg] = bus.core_ready_i;
      end
   end

   always_comb begin
      bus.rsp_valid_o  = '0;
      bus.core_ready_o = 1'b0;
      if (!fifo_empty) begin
         bus.rsp_valid_o[head] = bus.core_valid_i;
         bus.core_ready_o      = bus.rsp_ready_i[head];
      end
   end

   assign out_hs       = !fifo_empty && bus.core_valid_i && bus.rsp_ready_i[head];
   assign pop          = out_hs && (out_cnt_reg == CNT_LAST);
   assign frame_done_o = pop;
   assign busy_o       = (state_reg == LOCK) || !fifo_empty;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_reg      <= IDLE;
         grant_reg      <= '0;
         last_grant_reg <= GW'(NREQ - 1);
         in_cnt_reg     <= '0;
         out_cnt_reg    <= '0;
         wr_ptr_reg     <= '0;
         rd_ptr_reg     <= '0;
         count_reg      <= '0;
      end else begin
         state_reg      <= state_next;
         grant_reg      <= grant_next;
         last_grant_reg <= last_grant_next;
         in_cnt_reg     <= in_cnt_next;
         if (out_hs) out_cnt_reg <= out_cnt_reg + K'(1);
         if (push)   wr_ptr_reg  <= ptr_inc(wr_ptr_reg);
         if (pop)    rd_ptr_reg  <= ptr_inc(rd_ptr_reg);
         if (push && !pop)      count_reg <= count_reg + CW'(1);
         else if (pop && !push) count_reg <= count_reg - CW'(1);
      end
   end

   // Owner storage needs no reset: entries are only read while count_reg says they are valid.
   always_ff @(posedge clk_i) begin
      if (push) own_mem[wr_ptr_reg] <= grant_next;
   end
endmodule

// File: tb/tb_bitrev_arb.sv
// Self-checking bench for bitrev_arb (K=3, NREQ=4) with a double-buffered behavioural bitrev core.
// Per-lane expectation: each requester's words, cut into frames of N, come back bit-reversed.
module tb_bitrev_arb;
   localparam int NREQ = 4;
   localparam int K    = 3;
   localparam int N    = 8;
   localparam int DW   = 32;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic busy, frame_done;

   always #5 clk = ~clk;

   bitrev_arb_if #(.NREQ(NREQ), .DW(DW)) bus();

   bitrev_arb #(.NREQ(NREQ), .K(K), .DW(DW), .OWN_DEPTH(2)) dut (
      .clk_i       (clk),
      .rst_ni      (rst_n),
      .bus         (bus),
      .busy_o      (busy),
      .frame_done_o(frame_done)
   );

   function automatic int brev3(input int j);
      return ((j & 1) << 2) | (j & 2) | ((j >> 2) & 1);
   endfunction

   // Behavioural core: two frame slots, a frame is released once all N words are in.
   int c_in, c_out;
   logic [DW-1:0] cmem [16];
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         c_in  <= 0;
         c_out <= 0;
      end else begin
         if (bus.core_valid_o && bus.core_ready_i) begin
            cmem[c_in % 16] <= bus.core_data_o;
            c_in <= c_in + 1;
         end
         if (bus.core_valid_i && bus.core_ready_o) c_out <= c_out + 1;
      end
   end
   assign bus.core_ready_i = ((c_in / N) - (c_out / N)) < 2;
   assign bus.core_valid_i = c_in >= (c_out / N + 1) * N;
   assign bus.core_data_i  = bus.core_valid_i ? cmem[((c_out / N) % 2) * N + brev3(c_out % N)] : '0;

   int n_tests = 0;
   int n_fail  = 0;
   logic [31:0] src_mem [NREQ][64];
   int src_len [NREQ];
   int src_ptr [NREQ];
   bit src_en  [NREQ];
   logic [31:0] sent_buf [NREQ][N];
   int sent_n [NREQ];
   logic [31:0] exp_mem [NREQ][64];
   int exp_wr [NREQ];
   int exp_rd [NREQ];
   int out_idx [NREQ];
   int in_total, fd_count;
   int grant_log [$];
   bit rand_mode;
   logic [NREQ-1:0] rsp_rdy_set;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      n_tests++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %0h, required %0h", name, act, req);
      end
   endtask

   task automatic clear_tb();
      for (int r = 0; r < NREQ; r++) begin
         src_len[r] = 0; src_ptr[r] = 0; src_en[r] = 1'b0;
         sent_n[r] = 0; exp_wr[r] = 0; exp_rd[r] = 0; out_idx[r] = 0;
      end
      in_total = 0; fd_count = 0; grant_log.delete();
      rand_mode = 1'b0; rsp_rdy_set = '0;
   endtask

   task automatic load(input int r, input int nframes, input bit seq);
      for (int i = 0; i < nframes * N; i++) src_mem[r][i] = seq ? 32'(i) : $urandom;
      src_len[r] = nframes * N;
      src_ptr[r] = 0;
      src_en[r]  = 1'b1;
   endtask

   task automatic drive();
      for (int r = 0; r < NREQ; r++) begin
         bit v;
         v = src_en[r] && (src_ptr[r] < src_len[r]);
         if (rand_mode && $urandom_range(3) == 0) v = 1'b0;
         bus.req_valid_i[r] = v;
         bus.req_data_i[r*DW +: DW] = src_mem[r][src_ptr[r] % 64];
      end
      bus.rsp_ready_i = rand_mode ? NREQ'($urandom) : rsp_rdy_set;
   endtask

   // Called at the falling edge: records handshakes that complete on the next rising edge.
   task automatic monitor();
      logic hs_out;
      hs_out = 1'b0;
      if (frame_done) fd_count++;
      chk("rsp_onehot", logic'($countones(bus.rsp_valid_o) <= 1), 1'b1);
      for (int r = 0; r < NREQ; r++) begin
         if (bus.req_valid_i[r] && bus.req_ready_o[r]) begin
            if (in_total % N == 0) grant_log.push_back(r);
            in_total++;
            sent_buf[r][sent_n[r]] = bus.req_data_i[r*DW +: DW];
            sent_n[r]++;
            src_ptr[r]++;
            if (sent_n[r] == N) begin
               for (int j = 0; j < N; j++) exp_mem[r][(exp_wr[r] + j) % 64] = sent_buf[r][brev3(j)];
               exp_wr[r] += N;
               sent_n[r] = 0;
            end
         end
         if (bus.rsp_valid_o[r] && bus.rsp_ready_i[r]) begin
            hs_out = 1'b1;
            if (exp_rd[r] == exp_wr[r]) begin
               chk("rsp_valid_unexpected", bus.rsp_valid_o[r], 1'b0);
            end else begin
               chk("rsp_data", bus.rsp_data_o[r*DW +: DW], exp_mem[r][exp_rd[r] % 64]);
               chk("frame_done_beat", frame_done, logic'((out_idx[r] % N) == N - 1));
               if ((out_idx[r] % N) == N - 1) $display("[TB] lane %0d frame delivered", r);
               exp_rd[r]++;
               out_idx[r]++;
            end
         end
      end
      if (!hs_out) chk("frame_done_idle", frame_done, 1'b0);
   endtask

   task automatic cyc();
      @(posedge clk); #1;
      drive();
      @(negedge clk);
      monitor();
   endtask

   task automatic do_reset();
      @(posedge clk); #1;
      rst_n = 1'b0;
      clear_tb();
      drive();
      @(negedge clk);
      chk("rst_req_ready",  bus.req_ready_o, 0);
      chk("rst_rsp_valid",  bus.rsp_valid_o, 0);
      chk("rst_core_valid", bus.core_valid_o, 0);
      chk("rst_core_ready", bus.core_ready_o, 0);
      chk("rst_busy",       busy, 0);
      chk("rst_frame_done", frame_done, 0);
      @(posedge clk); #1;
      rst_n = 1'b1;
   endtask

   function automatic bit drained();
      bit d;
      d = !busy;
      for (int r = 0; r < NREQ; r++)
         if (src_ptr[r] != src_len[r] || sent_n[r] != 0 || exp_rd[r] != exp_wr[r]) d = 1'b0;
      return d;
   endfunction

   task automatic wait_drain(input int bound);
      int k;
      k = 0;
      while (k < bound && !drained()) begin
         cyc();
         k++;
      end
      chk("drain_done", drained(), 1'b1);
   endtask

   typedef struct {
      logic [3:0]  rsp_rdy;
      logic [3:0]  ready;
      logic [3:0]  rvalid;
      logic [31:0] rdata;
      logic        fd;
      logic        busy;
   } vec_t;

   vec_t tbl [18];
   int rr_exp [5] = '{0, 1, 2, 3, 0};
`ifdef BITREV_ARB_PRIO_EN
   int pr_exp [4] = '{0, 0, 0, 0};
`else
   int pr_exp [4] = '{0, 3, 0, 3};
`endif

   initial begin
      int k, tot;
      bit seen;
      bus.req_valid_i = '0;
      bus.req_data_i  = '0;
      bus.rsp_ready_i = '0;

      // Single frame from requester 2: grant at c0, input c1..c8, output c9..c16.
      for (int c = 0; c < 18; c++) begin
         tbl[c].rsp_rdy = 4'hF;
         tbl[c].ready   = (c >= 1 && c <= 8) ? 4'b0100 : 4'b0000;
         tbl[c].rvalid  = (c >= 9 && c <= 16) ? 4'b0100 : 4'b0000;
         tbl[c].rdata   = (c >= 9 && c <= 16) ? 32'(brev3(c - 9)) : 32'd0;
         tbl[c].fd      = (c == 16);
         tbl[c].busy    = (c >= 1 && c <= 16);
      end
      do_reset();
      load(2, 1, 1'b1);
      for (int c = 0; c < 18; c++) begin
         rsp_rdy_set = tbl[c].rsp_rdy;
         if (c == 0) begin
            drive();
            @(negedge clk);
            monitor();
         end else begin
            cyc();
         end
         chk("t1_req_ready", bus.req_ready_o, tbl[c].ready);
         chk("t1_rsp_valid", bus.rsp_valid_o, tbl[c].rvalid);
         chk("t1_frame_done", frame_done, tbl[c].fd);
         chk("t1_busy", busy, tbl[c].busy);
         if (tbl[c].rvalid != 0) chk("t1_rsp_data", bus.rsp_data_o[2*DW +: DW], tbl[c].rdata);
      end

      // All four requesters continuously valid: round-robin order.
      do_reset();
      for (int r = 0; r < NREQ; r++) load(r, 2, 1'b0);
      rsp_rdy_set = '1;
      wait_drain(400);
      for (int i = 0; i < 5; i++)
         chk("rr_order", (i < grant_log.size()) ? 64'(grant_log[i]) : 64'hFFFF, 64'(rr_exp[i]));

      // Owner FIFO full with responses blocked: third requester must wait for a pop.
      do_reset();
      load(0, 1, 1'b0); load(1, 1, 1'b0); load(2, 1, 1'b0);
      rsp_rdy_set = '0;
      repeat (40) cyc();
      chk("full_grants", grant_log.size(), 2);
      chk("full_req_ready", bus.req_ready_o, 0);
      chk("full_busy", busy, 1'b1);
      rsp_rdy_set = 4'b0001;
      seen = 1'b0;
      k = 0;
      while (!seen && k < 40) begin
         cyc();
         k++;
         if (frame_done) seen = 1'b1;
      end
      chk("full_pop_seen", seen, 1'b1);
      cyc();
      chk("full_decision_ready", bus.req_ready_o, 4'b0000);
      cyc();
      chk("full_grant_after_pop", bus.req_ready_o, 4'b0100);
      rsp_rdy_set = '1;
      wait_drain(100);
      chk("full_third_grant", (grant_log.size() > 2) ? 64'(grant_log[2]) : 64'hFFFF, 2);

      // Requester 1 stalls after word 3 while requester 3 waits.
      do_reset();
      load(1, 1, 1'b0); load(3, 1, 1'b0);
      src_en[3] = 1'b0;
      rsp_rdy_set = '1;
      k = 0;
      while (sent_n[1] < 4 && k < 30) begin
         cyc();
         k++;
      end
      chk("stall_reach", sent_n[1], 4);
      src_en[1] = 1'b0;
      src_en[3] = 1'b1;
      repeat (5) begin
         cyc();
         chk("stall_req_ready", bus.req_ready_o, 4'b0010);
         chk("stall_in_hold", sent_n[1], 4);
      end
      src_en[1] = 1'b1;
      wait_drain(100);
      chk("stall_first", (grant_log.size() > 0) ? 64'(grant_log[0]) : 64'hFFFF, 1);
      chk("stall_second", (grant_log.size() > 1) ? 64'(grant_log[1]) : 64'hFFFF, 3);

      // Requesters 0 and 3 always valid: build-dependent grant sequence.
      do_reset();
      load(0, 4, 1'b0); load(3, 4, 1'b0);
      rsp_rdy_set = '1;
      wait_drain(400);
      for (int i = 0; i < 4; i++)
         chk("prio_order", (i < grant_log.size()) ? 64'(grant_log[i]) : 64'hFFFF, 64'(pr_exp[i]));

      // Reset mid-frame, then a fresh frame.
      do_reset();
      load(2, 1, 1'b0);
      rsp_rdy_set = '1;
      k = 0;
      while (sent_n[2] < 5 && k < 30) begin
         cyc();
         k++;
      end
      chk("midrst_reach", sent_n[2], 5);
      do_reset();
      load(1, 1, 1'b0);
      rsp_rdy_set = '1;
      wait_drain(60);
      chk("midrst_frames", fd_count, 1);
      chk("midrst_grant", (grant_log.size() > 0) ? 64'(grant_log[0]) : 64'hFFFF, 1);

      // Randomized traffic with valid gaps and response back-pressure.
      do_reset();
      tot = 0;
      for (int r = 0; r < NREQ; r++) begin
         int nf;
         nf = $urandom_range(4);
         load(r, nf, 1'b0);
         tot += nf;
      end
      rand_mode = 1'b1;
      wait_drain(3000);
      rand_mode = 1'b0;
      chk("rand_frames", fd_count, tot);
      chk("rand_grants", grant_log.size(), tot);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule

// File: doc/bitrev_arb.md
# bitrev_arb

Frame-granular arbiter sharing one `bitrev` core among `NREQ` valid/ready streams. Each grant moves exactly one complete frame of `N = 2^K` words into the core; the matching reordered frame is steered back to the same requester's response port. Sits between the per-channel sample sources (FFT front-ends) and the single bit-reversal core.

## Interface

Parameters:
- `NREQ`, 4 — number of requesters (≥2).
- `K`, 10 — log2 frame length; must match the core.
- `DW`, 32 — data width; must match the core.
- `OWN_DEPTH`, 2 — frames in flight (owner FIFO depth, ≥1).

Ports (one clock; reset is asynchronous and active-low):
- `clk_i` in 1 — clock.
- `rst_ni` in 1 — asynchronous active-low reset.
- `req_valid_i` in NREQ — per-requester input valid.
- `req_data_i` in NREQ*DW — requester r in bits `[r*DW +: DW]`.
- `req_ready_o` out NREQ — per-requester input ready.
- `rsp_valid_o` out NREQ — per-requester output valid.
- `rsp_data_o` out NREQ*DW — output data, same packing.
- `rsp_ready_i` in NREQ — per-requester output ready.
- `core_valid_o` out 1 — to core `valid_i`.
- `core_data_o` out DW — to core `data_i`.
- `core_ready_i` in 1 — from core `ready_o`.
- `core_valid_i` in 1 — from core `valid_o`.
- `core_data_i` in DW — from core `data_o`.
- `core_ready_o` out 1 — to core `ready_i`.
- `busy_o` out 1 — high in LOCK or while the owner FIFO is non-empty.
- `frame_done_o` out 1 — one-cycle pulse on the last output beat of a frame.

## Operation

- Input FSM, states IDLE and LOCK:
  - IDLE: if any `req_valid_i` is high and the owner FIFO is not full, select the winner. Register `grant`, push `grant` into the owner FIFO, clear `in_cnt`, and go to LOCK.
  - LOCK: `core_valid_o = req_valid_i[grant]`, `core_data_o = req_data_i[grant]`, `req_ready_o[grant] = core_ready_i`, and all other readies are 0. Each handshake increments `in_cnt` (K bits). A handshake with `in_cnt == N-1` returns the FSM to IDLE.
- Round-robin: search starts at `last_grant+1` mod NREQ. `last_grant` resets to NREQ-1, so requester 0 wins first.
- Output side: when the owner FIFO is non-empty, `head` is the owner at the FIFO front.
  - `rsp_valid_o[head] = core_valid_i`, `rsp_data_o[head] = core_data_i`, `core_ready_o = rsp_ready_i[head]`.
  - Every handshake increments `out_cnt`. The handshake at `out_cnt == N-1` pops the FIFO and pulses `frame_done_o`.
  - FIFO empty: `core_ready_o = 0` and all `rsp_valid_o = 0`.
- Non-owner `rsp_data_o` lanes carry `core_data_i` (don't-care); only `rsp_valid_o` is qualified.
- A push (grant) and a pop (last output beat) in the same cycle are both performed, and the occupancy is unchanged.
- Full FIFO: IDLE stays in IDLE and no grant is issued until a pop occurs.
- Requester dropping valid mid-frame: the grant is held and `in_cnt` frozen. No timeout.
- Counters wrap naturally at N. Frames are never truncated.

## Timing

- Reset values:
  - State IDLE, `grant`=0, `last_grant`=NREQ-1, `in_cnt`=`out_cnt`=0, FIFO empty.
  - All outputs 0: `req_ready_o`, `rsp_valid_o`, `core_valid_o`, `core_ready_o`, `busy_o`, `frame_done_o`. Data outputs 0 while their valid is low.
- Data path latency is 0: input mux and output demux are purely combinational on the registered `grant`/`head`.
- Arbitration bubble: one cycle in IDLE between consecutive frames, so a back-to-back input frame costs N+1 cycles minimum.
- A grant is visible on `req_ready_o` one cycle after the IDLE decision cycle.
- `frame_done_o` is asserted combinationally in the same cycle as the final output handshake.
- Reset mid-operation clears all state immediately. The core must share `rst_ni` so that partial frames are discarded on both sides.

## Configuration

- `BITREV_ARB_PRIO_EN` defined: requester 0 has fixed highest priority and wins IDLE arbitration whenever `req_valid_i[0]` is high. The remaining requesters use round-robin among themselves.
- Not defined: pure round-robin over all NREQ requesters.
- Grant-at-frame-boundary semantics are identical in both builds.

## Test plan

Bench uses K=3 (N=8), NREQ=4, DW=32, with a `bitrev` core instance.
- Reset, then requester 2 sends words 0..7 → `req_ready_o`=0100 from the cycle after the grant. Outputs on `rsp_valid_o[2]` arrive in order 0,4,2,6,1,5,3,7. `frame_done_o` pulses once, then `busy_o` falls.
- All four requesters valid continuously, round-robin build → grant order 0,1,2,3,0. Each response port receives only its own bit-reversed frame.
- Two frames queued (OWN_DEPTH=2) with all `rsp_ready_i`=0 → the third requester is not granted (stays in IDLE). Raising `rsp_ready_i[owner0]` lets its frame drain, the pop fires, and the grant follows the next cycle.
- Requester 1 deasserts valid after word 3 for 5 cycles → `in_cnt` holds at 4, no other grant occurs, and the frame completes intact.
- `BITREV_ARB_PRIO_EN` build, requesters 0 and 3 always valid → requester 0 is granted every frame.
- Assert `rst_ni`=0 mid-frame (`in_cnt`=5) → all outputs are 0 next edge, the FIFO is empty, and a fresh frame after reset passes.
